// File: rtl/decompress_defines_pkg.sv
// Shared types, constants and the mode-to-width decode for the ML-KEM coefficient decompressor.
package decompress_defines_pkg;

    localparam int MLKEM_Q       = 3329;
    localparam int MLKEM_Q_WIDTH = 12;

    // Encodings 6 and 7 are illegal and are refused at start.
    typedef enum logic [2:0] {
        DECOMPRESS1  = 3'd0,
        DECOMPRESS5  = 3'd1,
        DECOMPRESS11 = 3'd2,
        DECOMPRESS4  = 3'd3,
        DECOMPRESS10 = 3'd4,
        DECOMPRESS12 = 3'd5
    } decompress_mode_t;

    typedef enum logic [1:0] {
        DCMP_IDLE = 2'd0,
        DCMP_RUN  = 2'd1,
        DCMP_DONE = 2'd2
    } decompress_state_t;

    // Returns 0 for an illegal encoding so callers can use it as a validity flag.
    function automatic logic [3:0] mode_to_d(input decompress_mode_t m);
        logic [3:0] d;
        case (m)
            DECOMPRESS1:  d = 4'd1;
            DECOMPRESS4:  d = 4'd4;
            DECOMPRESS5:  d = 4'd5;
            DECOMPRESS10: d = 4'd10;
            DECOMPRESS11: d = 4'd11;
            DECOMPRESS12: d = 4'd12;
            default:      d = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decompress_stream_if.sv
// Input word stream and output coefficient stream of decompress_stream.
interface decompress_if #(
    parameter int IN_W      = 64,
    parameter int NUM_LANES = 4
);
    // Both streams: a transfer happens on a rising clk edge where valid and ready are
    // both high; the source holds payload and valid stable until that edge.
    logic [IN_W-1:0]           data_i;
    logic                      data_valid_i;
    logic                      data_ready_o;
    logic [NUM_LANES*12-1:0]   coeff_o;
    logic                      coeff_valid_o;
    logic                      coeff_ready_i;

    modport master (
        output data_i, data_valid_i, coeff_ready_i,
        input  data_ready_o, coeff_o, coeff_valid_o
    );

    modport slave (
        input  data_i, data_valid_i, coeff_ready_i,
        output data_ready_o, coeff_o, coeff_valid_o
    );
endinterface

// File: rtl/decompress_stream_lane.sv
// One decompression lane: round(q*x / 2^d) for d < 12, sanitising bypass for d = 12.
module decompress_lane
    import decompress_defines_pkg::*;
(
    input  logic [MLKEM_Q_WIDTH-1:0] x_i,
    input  logic [3:0]               d_i,
    output logic [MLKEM_Q_WIDTH-1:0] y_o
);
    logic [23:0] prod;
    logic [23:0] rnd;

    always_comb begin
        prod = 24'(x_i) * 24'(MLKEM_Q);
        rnd  = 24'd1 << (d_i - 4'd1);
        if (d_i == 4'd12) begin
            y_o = (x_i < MLKEM_Q_WIDTH'(MLKEM_Q)) ? x_i : '0;
        end else begin
            y_o = MLKEM_Q_WIDTH'((prod + rnd) >> d_i);
        end
    end
endmodule

// File: rtl/decompress_stream.sv
// Streaming multi-lane ML-KEM decompressor: bit buffer, lane array, registered output beat.
// Define DECOMPRESS_RANGE_CHK_EN to enable the sticky err_o range flag in DECOMPRESS12.
module decompress_stream
    import decompress_defines_pkg::*;
#(
    parameter int IN_W      = 64,
    parameter int NUM_LANES = 4,
    parameter int COEFF_CNT = 256
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              zeroize,
    input  logic              start,
    input  decompress_mode_t  mode,
    decompress_if.slave       dif,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output decompress_state_t state_o
);
    localparam int LANE_W = MLKEM_Q_WIDTH;
    localparam int OUT_W  = NUM_LANES * LANE_W;
    localparam int BUF_W  = IN_W + OUT_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int BEATS  = COEFF_CNT / NUM_LANES;
    localparam int CNT_W  = $clog2(BEATS + 1);

    decompress_state_t state_q, state_d;
    logic [3:0]        d_q, d_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  beat_q, beat_d, cons_cnt_q, cons_cnt_d;
    logic [OUT_W-1:0]  coeff_q, coeff_d;
    logic              cv_q, cv_d, done_q, done_d, busy_q, busy_d, err_q, err_d;

    logic [FILL_W-1:0] need, fill_after;
    logic              run, consume, load, out_hs, data_ready;
    logic [3:0]        start_d;
    logic [LANE_W-1:0] mask;
    logic [NUM_LANES-1:0][LANE_W-1:0] lane_x, lane_y;

    // A 12-bit shift by 12 wraps to zero, so d = 12 yields an all-ones mask.
    assign mask = (LANE_W'(1) << d_q) - LANE_W'(1);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_x[k] = LANE_W'(buf_q >> (k * int'(d_q))) & mask;
        decompress_lane u_lane (
            .x_i (lane_x[k]),
            .d_i (d_q),
            .y_o (lane_y[k])
        );
    end

    always_comb begin
        run        = (state_q == DCMP_RUN);
        need       = FILL_W'(NUM_LANES * int'(d_q));
        out_hs     = cv_q && dif.coeff_ready_i;
        consume    = run && (cons_cnt_q < CNT_W'(BEATS)) && (fill_q >= need) &&
                     (!cv_q || dif.coeff_ready_i);
        fill_after = consume ? (fill_q - need) : fill_q;
        data_ready = run && (fill_after <= FILL_W'(BUF_W - IN_W));
        load       = data_ready && dif.data_valid_i;
        start_d    = mode_to_d(mode);

        state_d    = state_q;
        d_d        = d_q;
        buf_d      = consume ? (buf_q >> need) : buf_q;
        // New words land directly above the bits still waiting in the buffer.
        if (load) begin
            buf_d = buf_d | (BUF_W'(dif.data_i) << fill_after);
        end
        fill_d     = fill_after + (load ? FILL_W'(IN_W) : '0);
        cons_cnt_d = cons_cnt_q + CNT_W'(consume);
        beat_d     = beat_q + CNT_W'(out_hs);
        coeff_d    = consume ? lane_y : coeff_q;
        cv_d       = consume || (cv_q && !dif.coeff_ready_i);
        err_d      = err_q;
`ifdef DECOMPRESS_RANGE_CHK_EN
        for (int k = 0; k < NUM_LANES; k++) begin
            if (consume && (d_q == 4'd12) && (lane_x[k] >= LANE_W'(MLKEM_Q))) begin
                err_d = 1'b1;
            end
        end
`else
        err_d      = 1'b0;
`endif

        case (state_q)
            DCMP_IDLE: begin
                if (start && (start_d != 4'd0)) begin
                    state_d    = DCMP_RUN;
                    d_d        = start_d;
                    buf_d      = '0;
                    fill_d     = '0;
                    beat_d     = '0;
                    cons_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            DCMP_RUN: begin
                if (out_hs && (beat_q == CNT_W'(BEATS - 1))) begin
                    state_d = DCMP_DONE;
                end
            end
            DCMP_DONE: state_d = DCMP_IDLE;
            default:   state_d = DCMP_IDLE;
        endcase

        if (zeroize) begin
            state_d    = DCMP_IDLE;
            d_d        = '0;
            buf_d      = '0;
            fill_d     = '0;
            beat_d     = '0;
            cons_cnt_d = '0;
            coeff_d    = '0;
            cv_d       = 1'b0;
            err_d      = 1'b0;
        end

        done_d = (state_d == DCMP_DONE);
        busy_d = (state_d != DCMP_IDLE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= DCMP_IDLE;
            d_q        <= '0;
            buf_q      <= '0;
            fill_q     <= '0;
            beat_q     <= '0;
            cons_cnt_q <= '0;
            coeff_q    <= '0;
            cv_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            beat_q     <= beat_d;
            cons_cnt_q <= cons_cnt_d;
            coeff_q    <= coeff_d;
            cv_q       <= cv_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign dif.data_ready_o  = data_ready;
    assign dif.coeff_o       = coeff_q;
    assign dif.coeff_valid_o = cv_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_decompress_stream.sv
// Self-checking bench for decompress_stream: directed polynomials with a queued reference model.
module tb_decompress_stream;
    import decompress_defines_pkg::*;

`ifdef DECOMPRESS_RANGE_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              clk;
    logic              rst_b;
    logic              zeroize;
    logic              start;
    decompress_mode_t  mode;
    logic              busy;
    logic              done;
    logic              err;
    decompress_state_t state;

    decompress_if #(.IN_W(64), .NUM_LANES(4)) dif ();

    decompress_stream #(.IN_W(64), .NUM_LANES(4), .COEFF_CNT(256)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .zeroize (zeroize),
        .start   (start),
        .mode    (mode),
        .dif     (dif),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          cx [256];
    logic [63:0] words [48];
    int          n_words;
    bit          stop_send;
    logic [47:0] exp_q [$];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mode_d(input decompress_mode_t m);
        case (m)
            DECOMPRESS1:  return 1;
            DECOMPRESS4:  return 4;
            DECOMPRESS5:  return 5;
            DECOMPRESS10: return 10;
            DECOMPRESS11: return 11;
            default:      return 12;
        endcase
    endfunction

    function automatic logic [11:0] model(input int x, input int d);
        int r;
        if (d == 12) r = (x < 3329) ? x : 0;
        else         r = (x * 3329 + (1 << (d - 1))) >> d;
        return r[11:0];
    endfunction

    // Packs cx[] into the LSB-first word stream and queues the 64 expected beats.
    task automatic prep(input int d);
        int p;
        logic [47:0] e;
        for (int j = 0; j < 48; j++) words[j] = '0;
        for (int i = 0; i < 256; i++) begin
            for (int b = 0; b < d; b++) begin
                p = i * d + b;
                words[p / 64][p % 64] = cx[i][b];
            end
        end
        n_words = 256 * d / 64;
        for (int bt = 0; bt < 64; bt++) begin
            for (int k = 0; k < 4; k++) e[k*12 +: 12] = model(cx[bt*4 + k], d);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input decompress_mode_t m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_words(input int first, input int thr);
        int i;
        int cyc;
        i = first;
        cyc = 0;
        while (i < n_words && !stop_send && cyc < 3000) begin
            dif.data_valid_i = ($urandom_range(99) >= thr);
            dif.data_i       = words[i];
            #2;
            if (dif.data_valid_i && dif.data_ready_o) i++;
            @(posedge clk); #1;
            cyc++;
        end
        dif.data_valid_i = 1'b0;
        if (!stop_send) chk("send_all", i, n_words);
    endtask

    task automatic recv_beats(input int n, input int thr, output int cyc);
        int got;
        logic stalled;
        logic [47:0] held;
        logic [47:0] e;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (got < n && cyc < 3000) begin
            dif.coeff_ready_i = ($urandom_range(99) >= thr);
            if (stalled) begin
                chk("stall_valid", dif.coeff_valid_o, 1);
                chk("stall_hold", dif.coeff_o, held);
            end
            stalled = 1'b0;
            if (dif.coeff_valid_o) begin
                if (dif.coeff_ready_i) begin
                    if (exp_q.size() != 0) e = exp_q.pop_front();
                    else e = '1;
                    chk($sformatf("beat%0d", got), dif.coeff_o, e);
                    got++;
                end else begin
                    stalled = 1'b1;
                    held = dif.coeff_o;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        stop_send = 1'b1;
        dif.coeff_ready_i = 1'b0;
        chk("beat_count", got, n);
    endtask

    task automatic end_check(input string tag);
        chk({tag, "_done_hi"}, done, 1);
        chk({tag, "_busy_hi"}, busy, 1);
        chk({tag, "_valid_lo"}, dif.coeff_valid_o, 0);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        @(posedge clk); #1;
        chk({tag, "_done_lo"}, done, 0);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_idle"}, state, DCMP_IDLE);
    endtask

    task automatic run_poly(input decompress_mode_t m, input int thr_in, input int thr_out,
                            input bit pulse, output int cyc);
        prep(mode_d(m));
        do_start(m);
        chk("start_busy", busy, 1);
        chk("start_err_clear", err, 0);
        stop_send = 1'b0;
        fork
            send_words(0, thr_in);
            recv_beats(64, thr_out, cyc);
            begin
                if (pulse) begin
                    repeat (20) @(posedge clk);
                    #1;
                    start = 1'b1;
                    mode  = DECOMPRESS1;
                    @(posedge clk); #1;
                    start = 1'b0;
                    chk("start_ignored", state, DCMP_RUN);
                end
            end
        join
        end_check("poly");
    endtask

    initial begin
        int cyc;
        decompress_mode_t tm [4];
        int tx [4];

        checks = 0;
        errors = 0;
        rst_b = 1'b0;
        zeroize = 1'b0;
        start = 1'b0;
        mode = DECOMPRESS1;
        dif.data_i = '0;
        dif.data_valid_i = 1'b0;
        dif.coeff_ready_i = 1'b0;
        stop_send = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", dif.data_ready_o, 0);
        chk("rst_valid", dif.coeff_valid_o, 0);
        chk("rst_coeff", dif.coeff_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_state", state, DCMP_IDLE);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_coeff", dif.coeff_o, 0);
        chk("post_rst_busy", busy, 0);

        // Words offered while idle must not be taken.
        dif.data_valid_i = 1'b1;
        dif.data_i = '1;
        repeat (3) begin
            #2;
            chk("idle_ready", dif.data_ready_o, 0);
            @(posedge clk); #1;
        end
        dif.data_valid_i = 1'b0;

        // DECOMPRESS1 all ones, with first-word latency observed by hand.
        for (int i = 0; i < 256; i++) cx[i] = 1;
        prep(1);
        do_start(DECOMPRESS1);
        chk("d1_state_run", state, DCMP_RUN);
        chk("d1_busy", busy, 1);
        chk("d1_ready_s1", dif.data_ready_o, 1);
        dif.data_i = words[0];
        dif.data_valid_i = 1'b1;
        dif.coeff_ready_i = 1'b0;
        @(posedge clk); #1;
        dif.data_valid_i = 1'b0;
        chk("lat_not_yet", dif.coeff_valid_o, 0);
        @(posedge clk); #1;
        chk("lat_valid", dif.coeff_valid_o, 1);
        chk("lat_data", dif.coeff_o, exp_q[0]);
        stop_send = 1'b0;
        fork
            send_words(1, 0);
            recv_beats(64, 0, cyc);
        join
        end_check("d1");

        // Constant-value streams for each d < 12.
        tm[0] = DECOMPRESS11; tx[0] = 2047;
        tm[1] = DECOMPRESS10; tx[1] = 512;
        tm[2] = DECOMPRESS4;  tx[2] = 15;
        tm[3] = DECOMPRESS5;  tx[3] = 16;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) cx[i] = tx[t];
            run_poly(tm[t], 0, 0, 1'b0, cyc);
            if (t == 0) chk("d11_throughput", (cyc <= 68), 1);
        end

        // Random values exercise coefficients straddling word boundaries.
        for (int i = 0; i < 256; i++) cx[i] = $urandom_range(2047);
        run_poly(DECOMPRESS11, 0, 0, 1'b0, cyc);
        for (int i = 0; i < 256; i++) cx[i] = $urandom_range(1023);
        run_poly(DECOMPRESS10, 10, 10, 1'b0, cyc);

        // DECOMPRESS12 with a single out-of-range coefficient.
        for (int i = 0; i < 256; i++) cx[i] = $urandom_range(3328);
        cx[37] = 3329;
        run_poly(DECOMPRESS12, 0, 0, 1'b0, cyc);
        chk("d12_err", err, ERR_EXP);

        // Illegal mode: stays idle, err untouched.
        do_start(decompress_mode_t'(3'd7));
        chk("illegal_state", state, DCMP_IDLE);
        chk("illegal_busy", busy, 0);
        chk("illegal_err", err, ERR_EXP);
        #2;
        chk("illegal_ready", dif.data_ready_o, 0);
        @(posedge clk); #1;

        // Throttled DECOMPRESS5 on both sides.
        for (int i = 0; i < 256; i++) cx[i] = $urandom_range(31);
        run_poly(DECOMPRESS5, 30, 30, 1'b0, cyc);

        // DECOMPRESS12 over the full 12-bit range.
        for (int i = 0; i < 256; i++) cx[i] = $urandom_range(4095);
        run_poly(DECOMPRESS12, 20, 20, 1'b0, cyc);

        // Zeroize after beat 10.
        for (int i = 0; i < 256; i++) cx[i] = $urandom_range(31);
        prep(5);
        do_start(DECOMPRESS5);
        chk("zz_start_err", err, 0);
        stop_send = 1'b0;
        fork
            send_words(0, 0);
            recv_beats(11, 0, cyc);
        join
        dif.coeff_ready_i = 1'b0;
        dif.data_valid_i = 1'b0;
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        chk("zz_state", state, DCMP_IDLE);
        chk("zz_valid", dif.coeff_valid_o, 0);
        chk("zz_coeff", dif.coeff_o, 0);
        chk("zz_busy", busy, 0);
        chk("zz_err", err, 0);
        #2;
        chk("zz_ready", dif.data_ready_o, 0);
        @(posedge clk); #1;
        exp_q.delete();

        // Fresh polynomial after zeroize, with a stray start in the middle.
        for (int i = 0; i < 256; i++) cx[i] = $urandom_range(31);
        run_poly(DECOMPRESS5, 20, 20, 1'b1, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
